ddr_rng_unpack: RTL and testbench

DDR_RNG_UNPACK -- requirements
Module: ddr_rng_unpack

---
 rtl/ddr_rng_unpack.sv | 141 ++++++++++++++
 tb/tb_ddr_rng_unpack.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rng_unpack.sv
// Unpacks DDR read-back beats into SYM_W-bit random symbols, LSB-first.
// Two-deep beat buffer (active shift register + holding register) with underrun flag.
module ddr_rng_unpack #(
    parameter int DATA_W = 256,
    parameter int SYM_W  = 4
) (
    input  logic              clk200_i,
    input  logic              ddr_rd_rst_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              rd_en_4,
    output logic [SYM_W-1:0]  sym_o,
    output logic              sym_valid_o,
    output logic              underrun_o,
    output logic [47:0]       beat_count_o
);

    localparam int NSYM  = DATA_W / SYM_W;
    localparam int IDX_W = $clog2(NSYM);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSYM - 1);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  act_q, act_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [SYM_W-1:0]   sym_q, sym_d;
    logic               sym_valid_q, sym_valid_d;
    logic               underrun_q, underrun_d;
    logic [47:0]        beat_cnt_q, beat_cnt_d;
    logic               accept;

    // Reset is folded in so tready is low for the whole time reset is held.
    assign s_axis_tready = enable_i & ~ddr_rd_rst_i & (state_q != FULL);
    assign accept        = s_axis_tvalid & s_axis_tready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        act_d       = act_q;
        hold_d      = hold_q;
        sym_d       = sym_q;
        sym_valid_d = 1'b0;
        underrun_d  = underrun_q;
        beat_cnt_d  = beat_cnt_q;

        if (!enable_i) begin
            state_d    = EMPTY;
            idx_d      = '0;
            underrun_d = 1'b0;
        end else begin
            if (accept)
                beat_cnt_d = beat_cnt_q + 48'd1;
            if (rd_en_4 && state_q == EMPTY)
                underrun_d = 1'b1;

            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        act_d   = s_axis_tdata;
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (rd_en_4) begin
                        sym_d       = act_q[SYM_W-1:0];
                        sym_valid_d = 1'b1;
                        if (idx_q == LAST) begin
                            idx_d = '0;
                            // Same-cycle refill bypasses the holding register.
                            if (accept)
                                act_d = s_axis_tdata;
                            else
                                state_d = EMPTY;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            act_d = act_q >> SYM_W;
                            if (accept) begin
                                hold_d  = s_axis_tdata;
                                state_d = FULL;
                            end
                        end
                    end else if (accept) begin
                        hold_d  = s_axis_tdata;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (rd_en_4) begin
                        sym_d       = act_q[SYM_W-1:0];
                        sym_valid_d = 1'b1;
                        if (idx_q == LAST) begin
                            idx_d   = '0;
                            act_d   = hold_q;
                            state_d = ACTIVE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            act_d = act_q >> SYM_W;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk200_i or posedge ddr_rd_rst_i) begin
        if (ddr_rd_rst_i) begin
            state_q     <= EMPTY;
            idx_q       <= '0;
            act_q       <= '0;
            hold_q      <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            act_q       <= act_d;
            hold_q      <= hold_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            underrun_q  <= underrun_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign sym_o        = sym_q;
    assign sym_valid_o  = sym_valid_q;
    assign underrun_o   = underrun_q;
    assign beat_count_o = beat_cnt_q;

endmodule

// File: tb/tb_ddr_rng_unpack.sv
// Self-checking bench for ddr_rng_unpack: directed scenarios plus randomized traffic
// checked against a queue-of-beats reference model.
module tb_ddr_rng_unpack;

    localparam int DATA_W = 256;
    localparam int SYM_W  = 4;
    localparam int NSYM   = DATA_W / SYM_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              rd;
    logic [SYM_W-1:0]  sym;
    logic              svld;
    logic              und;
    logic [47:0]       cnt;

    always #5 clk = ~clk;

    ddr_rng_unpack #(.DATA_W(DATA_W), .SYM_W(SYM_W)) dut (
        .clk200_i     (clk),
        .ddr_rd_rst_i (rst),
        .enable_i     (en),
        .s_axis_tdata (tdata),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .rd_en_4      (rd),
        .sym_o        (sym),
        .sym_valid_o  (svld),
        .underrun_o   (und),
        .beat_count_o (cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a list of buffered beats and a read position in the oldest one.
    logic [DATA_W-1:0] m_q[$];
    int                m_pos;
    logic [SYM_W-1:0]  m_sym;
    bit                m_vld, m_und, m_acc;
    logic [47:0]       m_cnt;
    bit                rdy_obs, rdy_exp;

    function automatic logic [DATA_W-1:0] rand_beat();
        logic [DATA_W-1:0] b;
        for (int i = 0; i < DATA_W / 32; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_pos = 0; m_sym = '0; m_vld = 0; m_und = 0; m_cnt = '0;
    endtask

    // Drive one cycle, record tready before the edge, advance the model, settle after the edge.
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r);
        logic [DATA_W-1:0] head;
        tvalid = v; tdata = d; rd = r;
        #1;
        rdy_obs = tready;
        rdy_exp = !rst && en && (m_q.size() < 2);
        @(posedge clk);
        m_acc = 0; m_vld = 0;
        if (rst) m_reset();
        else if (!en) begin
            m_q.delete(); m_pos = 0; m_und = 0;
        end else begin
            m_acc = v && rdy_exp;
            if (r) begin
                if (m_q.size() == 0) m_und = 1;
                else begin
                    head  = m_q[0];
                    m_sym = SYM_W'(head >> (m_pos * SYM_W));
                    m_vld = 1;
                    m_pos++;
                    if (m_pos == NSYM) begin
                        void'(m_q.pop_front());
                        m_pos = 0;
                    end
                end
            end
            if (m_acc) begin
                m_q.push_back(d);
                m_cnt = m_cnt + 48'd1;
            end
        end
        #1;
    endtask

    task automatic flush();
        en = 0;
        step(0, '0, 0);
        en = 1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; tvalid = 0; tdata = '0; rd = 0;
        #2;
        n_chk++; if (tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %b want 0", tready); end
        n_chk++; if ({sym, svld, und} !== 6'd0) begin n_fail++; $display("FAIL reset_outs got sym=%h vld=%b und=%b want 0", sym, svld, und); end
        n_chk++; if (cnt !== 48'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        m_reset();
        step(0, '0, 0);
        step(0, '0, 0);
        rst = 0;
        #1;
        n_chk++; if (tready !== 1'b1) begin n_fail++; $display("FAIL reset_release_tready got %b want 1", tready); end
    endtask

    task automatic test_single_beat();
        logic [DATA_W-1:0] beat;
        logic [SYM_W-1:0]  e;
        beat = '0;
        beat[63:0] = 64'hFEDCBA9876543210;
        step(1, beat, 0);
        n_chk++; if (!rdy_obs) begin n_fail++; $display("FAIL single_accept got tready=%b want 1", rdy_obs); end
        for (int k = 0; k < NSYM; k++) begin
            step(0, '0, 1);
            e = (k < 16) ? SYM_W'(k) : '0;
            n_chk++;
            if (svld !== 1'b1 || sym !== e) begin
                n_fail++; $display("FAIL single_sym k=%0d got vld=%b sym=%h want vld=1 sym=%h", k, svld, sym, e);
            end
        end
        step(0, '0, 0);
        n_chk++; if (svld !== 1'b0) begin n_fail++; $display("FAIL single_idle_vld got %b want 0", svld); end
        n_chk++; if (cnt !== 48'd1) begin n_fail++; $display("FAIL single_cnt got %0d want 1", cnt); end
        step(0, '0, 1);
        n_chk++; if (und !== 1'b1 || svld !== 1'b0) begin n_fail++; $display("FAIL single_empty_after got und=%b vld=%b want und=1 vld=0", und, svld); end
        flush();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] bt[3];
        logic [47:0]       c0;
        int                nb;
        for (int i = 0; i < 3; i++) bt[i] = rand_beat();
        c0 = cnt; nb = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, bt[nb], 0);
            if (m_acc) nb++;
        end
        n_chk++; if (nb != 2 || tready !== 1'b0) begin n_fail++; $display("FAIL bp_full got accepted=%0d tready=%b want 2 and 0", nb, tready); end
        for (int k = 0; k < NSYM; k++) begin
            step(1, bt[2], 1);
            n_chk++;
            if (svld !== m_vld || sym !== m_sym || rdy_obs !== 1'b0) begin
                n_fail++; $display("FAIL bp_sym k=%0d got vld=%b sym=%h rdy=%b want vld=%b sym=%h rdy=0", k, svld, sym, rdy_obs, m_vld, m_sym);
            end
        end
        step(1, bt[2], 0);
        n_chk++; if (rdy_obs !== 1'b1) begin n_fail++; $display("FAIL bp_c_accept got tready=%b want 1", rdy_obs); end
        n_chk++; if (cnt !== c0 + 48'd3) begin n_fail++; $display("FAIL bp_cnt got %0d want %0d", cnt, c0 + 48'd3); end
        step(0, '0, 1);
        n_chk++; if (svld !== 1'b1 || sym !== bt[1][3:0]) begin n_fail++; $display("FAIL bp_b_active got sym=%h want %h", sym, bt[1][3:0]); end
        flush();
    endtask

    task automatic test_boundary();
        logic [DATA_W-1:0] x, y;
        x = rand_beat(); y = rand_beat();
        step(1, x, 0);
        for (int k = 0; k < NSYM - 1; k++) step(0, '0, 1);
        step(1, y, 1);
        n_chk++; if (rdy_obs !== 1'b1) begin n_fail++; $display("FAIL bnd_tready got %b want 1", rdy_obs); end
        n_chk++;
        if (svld !== 1'b1 || sym !== x[DATA_W-1 -: SYM_W] || und !== 1'b0) begin
            n_fail++; $display("FAIL bnd_last got vld=%b sym=%h und=%b want 1 %h 0", svld, sym, und, x[DATA_W-1 -: SYM_W]);
        end
        step(0, '0, 1);
        n_chk++; if (svld !== 1'b1 || sym !== y[3:0] || und !== 1'b0) begin n_fail++; $display("FAIL bnd_new0 got vld=%b sym=%h und=%b want 1 %h 0", svld, sym, und, y[3:0]); end
        flush();
    endtask

    task automatic test_underrun();
        step(0, '0, 1);
        n_chk++; if (und !== 1'b1 || svld !== 1'b0) begin n_fail++; $display("FAIL und_set got und=%b vld=%b want 1 0", und, svld); end
        step(1, rand_beat(), 1);
        n_chk++; if (und !== 1'b1 || svld !== 1'b0 || !m_acc) begin n_fail++; $display("FAIL und_accept got und=%b vld=%b want 1 0", und, svld); end
        step(0, '0, 1);
        n_chk++; if (und !== 1'b1 || svld !== 1'b1 || sym !== m_sym) begin n_fail++; $display("FAIL und_sticky got und=%b vld=%b sym=%h want 1 1 %h", und, svld, sym, m_sym); end
        flush();
        n_chk++; if (und !== 1'b0) begin n_fail++; $display("FAIL und_clear got %b want 0", und); end
    endtask

    task automatic test_enable_flush();
        logic [47:0] c0;
        step(1, rand_beat(), 0);
        step(1, rand_beat(), 0);
        n_chk++; if (tready !== 1'b0) begin n_fail++; $display("FAIL en_full got tready=%b want 0", tready); end
        c0 = cnt;
        en = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, rand_beat(), 1);
            n_chk++; if (rdy_obs !== 1'b0 || svld !== 1'b0 || und !== 1'b0) begin n_fail++; $display("FAIL en_off i=%0d got rdy=%b vld=%b und=%b want 0 0 0", i, rdy_obs, svld, und); end
        end
        en = 1;
        #1;
        n_chk++; if (tready !== 1'b1 || cnt !== c0) begin n_fail++; $display("FAIL en_back got tready=%b cnt=%0d want 1 %0d", tready, cnt, c0); end
        step(0, '0, 1);
        n_chk++; if (und !== 1'b1 || svld !== 1'b0) begin n_fail++; $display("FAIL en_flushed got und=%b vld=%b want 1 0", und, svld); end
        flush();
    endtask

    task automatic test_async_reset();
        step(1, {NSYM{4'hA}}, 0);
        step(1, rand_beat(), 0);
        for (int k = 0; k < 20; k++) step(0, '0, 1);
        n_chk++; if (sym !== 4'hA || cnt === 48'd0) begin n_fail++; $display("FAIL arst_pre got sym=%h cnt=%0d want a and nonzero", sym, cnt); end
        #2;
        rst = 1;
        #1;
        n_chk++;
        if ({sym, svld, und} !== 6'd0 || cnt !== 48'd0 || tready !== 1'b0) begin
            n_fail++; $display("FAIL arst_now got sym=%h vld=%b und=%b cnt=%0d rdy=%b want all 0", sym, svld, und, cnt, tready);
        end
        m_reset();
        step(0, '0, 0);
        rst = 0;
        step(0, '0, 1);
        n_chk++; if (und !== 1'b1 || svld !== 1'b0) begin n_fail++; $display("FAIL arst_und got und=%b vld=%b want 1 0", und, svld); end
        flush();
    endtask

    task automatic test_random();
        int off = 0;
        for (int c = 0; c < 3000; c++) begin
            if (off > 0) off--;
            else if ($urandom_range(0, 99) == 0) off = $urandom_range(1, 3);
            en = (off == 0);
            step($urandom_range(0, 2) != 0, rand_beat(), $urandom_range(0, 9) < 7);
            n_chk++;
            if (rdy_obs !== rdy_exp || svld !== m_vld || sym !== m_sym || und !== m_und || cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL rand c=%0d got rdy=%b vld=%b sym=%h und=%b cnt=%0d want %b %b %h %b %0d",
                         c, rdy_obs, svld, sym, und, cnt, rdy_exp, m_vld, m_sym, m_und, m_cnt);
            end
        end
        en = 1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_boundary();
        test_underrun();
        test_enable_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
